axi_modport: RTL and testbench

- Passive AXI4 protocol checker and handshake counter for one master port (M2-style).
- Sits beside the master port and taps all five channels read-only; never drives any AXI signal.
- Reports sticky error flags, a one-cycle error pulse, per-channel handshake counts and outstanding-transaction depth.

---
 rtl/axi_modport.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_axi_modport.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_modport.sv
// axi_modport: passive AXI4 master-port checker with sticky error flags and handshake counters.
// Build option: define AXI_READY_HOLD_CHECK_EN to flag BREADY/RREADY dropped while still waiting for VALID.

// Burst-length queue plus beat counter: checks the LAST flag of each data beat against the queued length.
module axi_modport_lenq #(
    parameter int unsigned LEN_WIDTH = 4,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [LEN_WIDTH-1:0] push_len,
    input  logic                 beat,
    input  logic                 last,
    output logic                 full_c,
    output logic                 last_err_c
);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned BEAT_W = LEN_WIDTH + 1;

    logic [LEN_WIDTH-1:0] len_mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [BEAT_W-1:0]    beat_cnt;

    logic                 empty;
    logic                 head_ok;
    logic [LEN_WIDTH-1:0] head_len;
    logic                 expect_last;
    logic                 pop;
    logic                 bypass;
    logic                 do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // An empty queue with a same-cycle push checks the incoming length directly;
    // if that beat also closes the burst, the entry is consumed without being stored.
    always_comb begin
        empty       = (count == '0);
        full_c      = (count == CNT_W'(DEPTH));
        head_ok     = !empty || push;
        head_len    = empty ? push_len : len_mem[rd_ptr];
        expect_last = (beat_cnt == {1'b0, head_len});
        last_err_c  = beat && (!head_ok || (last != expect_last));
        pop         = beat && last && !empty;
        bypass      = beat && last && empty && push;
        do_push     = push && !full_c && !bypass;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(pop);
            if (beat) begin
                beat_cnt <= last ? '0 : beat_cnt + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            len_mem[wr_ptr] <= push_len;
        end
    end
endmodule

module axi_modport #(
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned LEN_WIDTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic [ID_WIDTH-1:0]                AWID,
    input  logic [ADDR_WIDTH-1:0]              AWADDR,
    input  logic [LEN_WIDTH-1:0]               AWLEN,
    input  logic [2:0]                         AWSIZE,
    input  logic [1:0]                         AWBURST,
    input  logic                               AWVALID,
    input  logic                               AWREADY,
    input  logic [DATA_WIDTH-1:0]              WDATA,
    input  logic [DATA_WIDTH/8-1:0]            WSTRB,
    input  logic                               WLAST,
    input  logic                               WVALID,
    input  logic                               WREADY,
    input  logic [ID_WIDTH-1:0]                BID,
    input  logic [1:0]                         BRESP,
    input  logic                               BVALID,
    input  logic                               BREADY,
    input  logic [ID_WIDTH-1:0]                ARID,
    input  logic [ADDR_WIDTH-1:0]              ARADDR,
    input  logic [LEN_WIDTH-1:0]               ARLEN,
    input  logic [2:0]                         ARSIZE,
    input  logic [1:0]                         ARBURST,
    input  logic                               ARVALID,
    input  logic                               ARREADY,
    input  logic [ID_WIDTH-1:0]                RID,
    input  logic [DATA_WIDTH-1:0]              RDATA,
    input  logic [1:0]                         RRESP,
    input  logic                               RLAST,
    input  logic                               RVALID,
    input  logic                               RREADY,
    output logic [11:0]                        err_vector,
    output logic                               err_pulse,
    output logic [15:0]                        aw_cnt,
    output logic [15:0]                        w_cnt,
    output logic [15:0]                        b_cnt,
    output logic [15:0]                        ar_cnt,
    output logic [15:0]                        r_cnt,
    output logic [$clog2(MAX_OUTSTANDING):0]   wr_outstanding,
    output logic [$clog2(MAX_OUTSTANDING):0]   rd_outstanding
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned A_PL_W     = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 5;
    localparam int unsigned W_PL_W     = DATA_WIDTH + STRB_WIDTH + 1;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last_hs;
    logic [A_PL_W-1:0] aw_pl, ar_pl;
    logic [W_PL_W-1:0] w_pl;

    logic              aw_stall_q, w_stall_q, ar_stall_q;
    logic [A_PL_W-1:0] aw_snap_q, ar_snap_q;
    logic [W_PL_W-1:0] w_snap_q;

    logic aw_full, ar_full, w_last_err, r_last_err;
    logic aw_open, ar_open;
    logic [1:0]  hold_det;
    logic [11:0] det;

    logic unused_payload;

    // Response-side payloads are not checked; folded here so they stay visibly tapped.
    assign unused_payload = ^{BID, BRESP, RID, RDATA, RRESP};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && !(&c)) ? c + CNT_W'(1) : c;
    endfunction

    // Opening and closing in the same cycle cancel; never underflow, saturate at the top.
    function automatic logic [OUT_W-1:0] track(input logic [OUT_W-1:0] cur,
                                               input logic open, input logic close);
        if (open && !close) begin
            return (&cur) ? cur : cur + OUT_W'(1);
        end
        if (close && !open) begin
            return (cur == '0) ? cur : cur - OUT_W'(1);
        end
        return cur;
    endfunction

    always_comb begin
        aw_hs     = AWVALID && AWREADY;
        w_hs      = WVALID && WREADY;
        b_hs      = BVALID && BREADY;
        ar_hs     = ARVALID && ARREADY;
        r_hs      = RVALID && RREADY;
        r_last_hs = r_hs && RLAST;
        aw_pl     = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
        ar_pl     = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
        w_pl      = {WDATA, WSTRB, WLAST};
        aw_open   = aw_hs && !aw_full;
        ar_open   = ar_hs && !ar_full;
    end

    axi_modport_lenq #(
        .LEN_WIDTH (LEN_WIDTH),
        .DEPTH     (MAX_OUTSTANDING)
    ) u_aw_q (
        .clk        (ACLK),
        .rst        (ARESET),
        .push       (aw_hs),
        .push_len   (AWLEN),
        .beat       (w_hs),
        .last       (WLAST),
        .full_c     (aw_full),
        .last_err_c (w_last_err)
    );

    axi_modport_lenq #(
        .LEN_WIDTH (LEN_WIDTH),
        .DEPTH     (MAX_OUTSTANDING)
    ) u_ar_q (
        .clk        (ACLK),
        .rst        (ARESET),
        .push       (ar_hs),
        .push_len   (ARLEN),
        .beat       (r_hs),
        .last       (RLAST),
        .full_c     (ar_full),
        .last_err_c (r_last_err)
    );

`ifdef AXI_READY_HOLD_CHECK_EN
    logic bready_idle_q;
    logic rready_idle_q;

    // READY raised ahead of VALID must stay up until the handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bready_idle_q <= 1'b0;
            rready_idle_q <= 1'b0;
        end else begin
            bready_idle_q <= BREADY && !BVALID;
            rready_idle_q <= RREADY && !RVALID;
        end
    end

    assign hold_det = {rready_idle_q && !RREADY, bready_idle_q && !BREADY};
`else
    assign hold_det = 2'b00;
`endif

    always_comb begin
        det      = '0;
        det[0]   = aw_stall_q && !AWVALID;
        det[1]   = w_stall_q && !WVALID;
        det[2]   = ar_stall_q && !ARVALID;
        det[3]   = aw_stall_q && AWVALID && (aw_pl != aw_snap_q);
        det[4]   = w_stall_q && WVALID && (w_pl != w_snap_q);
        det[5]   = ar_stall_q && ARVALID && (ar_pl != ar_snap_q);
        det[6]   = w_last_err;
        det[7]   = r_last_err;
        det[8]   = (b_hs && (wr_outstanding == '0)) || (r_last_hs && (rd_outstanding == '0));
        det[9]   = (aw_hs && aw_full) || (ar_hs && ar_full);
        det[11:10] = hold_det;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_stall_q     <= 1'b0;
            w_stall_q      <= 1'b0;
            ar_stall_q     <= 1'b0;
            aw_snap_q      <= '0;
            w_snap_q       <= '0;
            ar_snap_q      <= '0;
            err_vector     <= '0;
            err_pulse      <= 1'b0;
            aw_cnt         <= '0;
            w_cnt          <= '0;
            b_cnt          <= '0;
            ar_cnt         <= '0;
            r_cnt          <= '0;
            wr_outstanding <= '0;
            rd_outstanding <= '0;
        end else begin
            aw_stall_q <= AWVALID && !AWREADY;
            w_stall_q  <= WVALID && !WREADY;
            ar_stall_q <= ARVALID && !ARREADY;
            if (AWVALID && !AWREADY) begin
                aw_snap_q <= aw_pl;
            end
            if (WVALID && !WREADY) begin
                w_snap_q <= w_pl;
            end
            if (ARVALID && !ARREADY) begin
                ar_snap_q <= ar_pl;
            end
            err_vector     <= err_vector | det;
            err_pulse      <= |(det & ~err_vector);
            aw_cnt         <= sat_inc(aw_cnt, aw_hs);
            w_cnt          <= sat_inc(w_cnt, w_hs);
            b_cnt          <= sat_inc(b_cnt, b_hs);
            ar_cnt         <= sat_inc(ar_cnt, ar_hs);
            r_cnt          <= sat_inc(r_cnt, r_hs);
            wr_outstanding <= track(wr_outstanding, aw_open, b_hs);
            rd_outstanding <= track(rd_outstanding, ar_open, r_last_hs);
        end
    end
endmodule

// File: tb/tb_axi_modport.sv
// tb_axi_modport: directed and randomized stimulus for axi_modport, checked cycle by cycle
// against a queue-based model of the protocol rules.
module tb_axi_modport;
    localparam int ID_W    = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 4;
    localparam int MAXO    = 4;
    localparam int STRB_W  = DATA_W / 8;
    localparam int OUT_W   = $clog2(MAXO) + 1;
    localparam int OUT_MAX = (1 << OUT_W) - 1;
    localparam int A_PL_W  = ID_W + ADDR_W + LEN_W + 5;
    localparam int W_PL_W  = DATA_W + STRB_W + 1;

    logic ACLK = 1'b0;
    logic ARESET;
    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [LEN_W-1:0]  AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWVALID, AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST, WVALID, WREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID, BREADY;
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID, ARREADY;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST, RVALID, RREADY;
    logic [11:0]       err_vector;
    logic              err_pulse;
    logic [15:0]       aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [OUT_W-1:0]  wr_outstanding, rd_outstanding;

    always #5 ACLK = ~ACLK;

    axi_modport #(
        .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W),
        .LEN_WIDTH(LEN_W), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .err_vector(err_vector), .err_pulse(err_pulse),
        .aw_cnt(aw_cnt), .w_cnt(w_cnt), .b_cnt(b_cnt), .ar_cnt(ar_cnt), .r_cnt(r_cnt),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int aw_q[$];
    int ar_q[$];
    int w_beat, r_beat, wr_out, rd_out;
    int cnt[5];
    logic [11:0] m_err;
    logic        m_pulse;
    logic        m_aw_st, m_w_st, m_ar_st, m_bidle, m_ridle;
    logic [A_PL_W-1:0] m_aw_snap, m_ar_snap;
    logic [W_PL_W-1:0] m_w_snap;

    function automatic logic [A_PL_W-1:0] aw_pl();
        return {AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
    endfunction
    function automatic logic [A_PL_W-1:0] ar_pl();
        return {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
    endfunction
    function automatic logic [W_PL_W-1:0] w_pl();
        return {WDATA, WSTRB, WLAST};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies one clock of the protocol rules to the inputs currently on the pins.
    task automatic model_step();
        logic [11:0] det;
        int  sz, len;
        bit  aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last, opened;
        det = '0;
        if (ARESET) begin
            aw_q.delete();
            ar_q.delete();
            w_beat = 0; r_beat = 0; wr_out = 0; rd_out = 0;
            foreach (cnt[i]) cnt[i] = 0;
            m_err = '0; m_pulse = 1'b0;
            m_aw_st = 1'b0; m_w_st = 1'b0; m_ar_st = 1'b0; m_bidle = 1'b0; m_ridle = 1'b0;
            return;
        end
        aw_hs = AWVALID && AWREADY;
        w_hs  = WVALID && WREADY;
        b_hs  = BVALID && BREADY;
        ar_hs = ARVALID && ARREADY;
        r_hs  = RVALID && RREADY;
        r_last = r_hs && RLAST;

        if (m_aw_st && !AWVALID) det[0] = 1'b1;
        if (m_w_st && !WVALID)   det[1] = 1'b1;
        if (m_ar_st && !ARVALID) det[2] = 1'b1;
        if (m_aw_st && AWVALID && aw_pl() != m_aw_snap) det[3] = 1'b1;
        if (m_w_st && WVALID && w_pl() != m_w_snap)     det[4] = 1'b1;
        if (m_ar_st && ARVALID && ar_pl() != m_ar_snap) det[5] = 1'b1;
`ifdef AXI_READY_HOLD_CHECK_EN
        if (m_bidle && !BREADY) det[10] = 1'b1;
        if (m_ridle && !RREADY) det[11] = 1'b1;
`endif

        // write side
        sz = aw_q.size();
        if (w_hs) begin
            len = (sz > 0) ? aw_q[0] : (aw_hs ? int'(AWLEN) : -1);
            if (len < 0 || WLAST != (w_beat == len)) det[6] = 1'b1;
            w_beat = WLAST ? 0 : w_beat + 1;
        end
        if (aw_hs && sz == MAXO) det[9] = 1'b1;
        opened = aw_hs && sz < MAXO;
        if (w_hs && WLAST && sz > 0) void'(aw_q.pop_front());
        if (opened && !(w_hs && WLAST && sz == 0)) aw_q.push_back(int'(AWLEN));
        if (b_hs && wr_out == 0) det[8] = 1'b1;
        if (opened && !b_hs) wr_out = (wr_out < OUT_MAX) ? wr_out + 1 : wr_out;
        else if (b_hs && !opened && wr_out > 0) wr_out = wr_out - 1;

        // read side
        sz = ar_q.size();
        if (r_hs) begin
            len = (sz > 0) ? ar_q[0] : (ar_hs ? int'(ARLEN) : -1);
            if (len < 0 || RLAST != (r_beat == len)) det[7] = 1'b1;
            r_beat = RLAST ? 0 : r_beat + 1;
        end
        if (ar_hs && sz == MAXO) det[9] = 1'b1;
        opened = ar_hs && sz < MAXO;
        if (r_last && sz > 0) void'(ar_q.pop_front());
        if (opened && !(r_last && sz == 0)) ar_q.push_back(int'(ARLEN));
        if (r_last && rd_out == 0) det[8] = 1'b1;
        if (opened && !r_last) rd_out = (rd_out < OUT_MAX) ? rd_out + 1 : rd_out;
        else if (r_last && !opened && rd_out > 0) rd_out = rd_out - 1;

        if (aw_hs && cnt[0] < 65535) cnt[0]++;
        if (w_hs  && cnt[1] < 65535) cnt[1]++;
        if (b_hs  && cnt[2] < 65535) cnt[2]++;
        if (ar_hs && cnt[3] < 65535) cnt[3]++;
        if (r_hs  && cnt[4] < 65535) cnt[4]++;

        m_pulse = |(det & ~m_err);
        m_err   = m_err | det;

        m_aw_st = AWVALID && !AWREADY;
        m_w_st  = WVALID && !WREADY;
        m_ar_st = ARVALID && !ARREADY;
        if (m_aw_st) m_aw_snap = aw_pl();
        if (m_w_st)  m_w_snap  = w_pl();
        if (m_ar_st) m_ar_snap = ar_pl();
        m_bidle = BREADY && !BVALID;
        m_ridle = RREADY && !RVALID;
    endtask

    task automatic compare_all();
        check("err_vector", err_vector, m_err);
        check("err_pulse", err_pulse, m_pulse);
        check("aw_cnt", aw_cnt, cnt[0]);
        check("w_cnt", w_cnt, cnt[1]);
        check("b_cnt", b_cnt, cnt[2]);
        check("ar_cnt", ar_cnt, cnt[3]);
        check("r_cnt", r_cnt, cnt[4]);
        check("wr_outstanding", wr_outstanding, wr_out);
        check("rd_outstanding", rd_outstanding, rd_out);
    endtask

    task automatic tick();
        model_step();
        @(posedge ACLK);
        #1;
        compare_all();
    endtask

    task automatic idle();
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 0; AWREADY = 0;
        WDATA = '0; WSTRB = '0; WLAST = 0; WVALID = 0; WREADY = 0;
        BID = '0; BRESP = '0; BVALID = 0; BREADY = 0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 0; ARREADY = 0;
        RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0; RREADY = 0;
    endtask

    task automatic do_reset();
        idle();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
    endtask

    initial begin
        int exp_len;
        idle();
        ARESET = 1'b1;
        tick();
        check("reset_err_vector", err_vector, 0);
        check("reset_wr_outstanding", wr_outstanding, 0);
        ARESET = 1'b0;

        // AW stalled three cycles with stable payload, then accepted
        AWVALID = 1; AWADDR = 32'h100; AWLEN = 4'd0; AWID = 4'h3;
        repeat (3) tick();
        AWREADY = 1;
        tick();
        idle();
        tick();
        check("t1_aw_cnt", aw_cnt, 1);
        check("t1_wr_out", wr_outstanding, 1);
        check("t1_err", err_vector, 0);

        // AWVALID withdrawn after a stall
        do_reset();
        AWVALID = 1;
        tick();
        AWVALID = 0;
        tick();
        check("t2_err0", err_vector[0], 1);
        check("t2_pulse_hi", err_pulse, 1);
        tick();
        check("t2_pulse_lo", err_pulse, 0);

        // AR address changes while stalled
        do_reset();
        ARVALID = 1; ARADDR = 32'h1000;
        tick();
        ARADDR = 32'h2000;
        tick();
        check("t3_err5", err_vector[5], 1);
        idle();
        tick();

        // Four-beat write burst, then response
        do_reset();
        AWVALID = 1; AWREADY = 1; AWLEN = 4'd3;
        tick();
        idle();
        WVALID = 1; WREADY = 1;
        for (int i = 0; i < 4; i++) begin
            WDATA = 32'hA000 + i;
            WLAST = (i == 3);
            tick();
        end
        idle();
        BVALID = 1; BREADY = 1;
        tick();
        idle();
        tick();
        check("t4_w_cnt", w_cnt, 4);
        check("t4_b_cnt", b_cnt, 1);
        check("t4_wr_out", wr_outstanding, 0);
        check("t4_err", err_vector, 0);
        // same burst with WLAST early on beat 2
        AWVALID = 1; AWREADY = 1; AWLEN = 4'd3;
        tick();
        idle();
        WVALID = 1; WREADY = 1;
        WLAST = 0; tick();
        WLAST = 1; tick();
        idle();
        tick();
        check("t4_err6", err_vector[6], 1);

        // AR queue overflow, drain, then an orphan RLAST
        do_reset();
        ARVALID = 1; ARREADY = 1; ARLEN = 4'd0;
        for (int i = 0; i < 5; i++) begin
            ARID = 4'(i);
            tick();
        end
        idle();
        tick();
        check("t5_err9", err_vector[9], 1);
        check("t5_rd_out_full", rd_outstanding, 4);
        RVALID = 1; RREADY = 1; RLAST = 1;
        repeat (4) tick();
        check("t5_rd_out_drained", rd_outstanding, 0);
        tick();
        idle();
        tick();
        check("t5_err8", err_vector[8], 1);
        check("t5_err_all", err_vector, 12'h380);

        // Reset in the middle of an eight-beat write burst
        do_reset();
        AWVALID = 1; AWREADY = 1; AWLEN = 4'd7;
        tick();
        idle();
        WVALID = 1; WREADY = 1; WLAST = 0;
        repeat (3) tick();
        ARESET = 1;
        tick();
        check("t6_rst_err", err_vector, 0);
        check("t6_rst_aw_cnt", aw_cnt, 0);
        check("t6_rst_w_cnt", w_cnt, 0);
        check("t6_rst_wr_out", wr_outstanding, 0);
        ARESET = 0;
        idle();
        AWVALID = 1; AWREADY = 1; AWLEN = 4'd0;
        tick();
        idle();
        WVALID = 1; WREADY = 1; WLAST = 1;
        tick();
        idle();
        BVALID = 1; BREADY = 1;
        tick();
        idle();
        tick();
        check("t6_err", err_vector, 0);
        check("t6_w_cnt", w_cnt, 1);
        check("t6_b_cnt", b_cnt, 1);
        check("t6_wr_out", wr_outstanding, 0);

        // Randomized traffic, mostly protocol-conformant, with periodic resets
        for (int c = 0; c < 1536; c++) begin
            if (c % 96 == 0) do_reset();
            if (m_aw_st && $urandom_range(7) != 0) begin
                AWVALID = 1;
            end else begin
                AWVALID = ($urandom_range(3) == 0);
                AWID = ID_W'($urandom); AWADDR = $urandom; AWLEN = LEN_W'($urandom_range(3));
                AWSIZE = 3'($urandom_range(2)); AWBURST = 2'($urandom_range(2));
            end
            AWREADY = 1'($urandom_range(1));
            if (m_w_st && $urandom_range(7) != 0) begin
                WVALID = 1;
            end else begin
                WVALID = 1'($urandom_range(1));
                WDATA = $urandom; WSTRB = STRB_W'($urandom);
                exp_len = (aw_q.size() > 0) ? aw_q[0] : int'(AWLEN);
                WLAST = ($urandom_range(7) != 0) ? (w_beat == exp_len) : 1'($urandom_range(1));
            end
            WREADY = 1'($urandom_range(1));
            BVALID = 1'($urandom_range(1));
            BREADY = ($urandom_range(3) != 0);
            BID = ID_W'($urandom); BRESP = 2'($urandom);
            if (m_ar_st && $urandom_range(7) != 0) begin
                ARVALID = 1;
            end else begin
                ARVALID = ($urandom_range(3) == 0);
                ARID = ID_W'($urandom); ARADDR = $urandom; ARLEN = LEN_W'($urandom_range(3));
                ARSIZE = 3'($urandom_range(2)); ARBURST = 2'($urandom_range(2));
            end
            ARREADY = 1'($urandom_range(1));
            RVALID = 1'($urandom_range(1));
            RREADY = ($urandom_range(3) != 0);
            RID = ID_W'($urandom); RDATA = $urandom; RRESP = 2'($urandom);
            exp_len = (ar_q.size() > 0) ? ar_q[0] : int'(ARLEN);
            RLAST = ($urandom_range(7) != 0) ? (r_beat == exp_len) : 1'($urandom_range(1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
